k_fifo_rd_stream_t1: RTL and testbench
======================================

// Module: k_fifo_rd_stream_t1
// PURPOSE
//  Read-domain consumer stage that sits directly downstream of the async FIFO read port.
//  Pops words via rget/rempty/rdata and re-presents them as a registered valid/ready stream.
//  A 2-entry elastic buffer gives full throughput and registered outputs toward the sink.
//  Also keeps pop and back-pressure statistics.
//  Entirely in the rclk domain.
// PARAMETERS
//  data_size  8   width of FIFO words and of o_data
//  cnt_size   16  width of the pop_cnt and stall_cnt statistics counters
// PORTS
//  rclk       in   1          read-domain clock
//  rrst       in   1          synchronous reset, active-high
//  rdata      in   data_size  FIFO read data; show-ahead, valid whenever rempty=0
//  rempty     in   1          FIFO empty flag (registered in the FIFO read control)
//  rget       out  1          pop strobe to the FIFO; consumes rdata in the same cycle
//  en         in   1          1 = allow popping; 0 = hold (buffer still drains)
//  flush      in   1          synchronous clear of buffered words
//  o_valid    out  1          o_data holds a valid word
//  o_ready    in   1          sink accepts o_data this cycle
//  o_data     out  data_size  head word of the elastic buffer, registered
//  level      out  2          buffered word count, 0..2
//  pop_cnt    out  cnt_size   total words popped from the FIFO; wraps
//  stall_cnt  out  cnt_size   cycles with o_valid=1 and o_ready=0; saturates
// BEHAVIOUR
//  Reset (rrst=1 at rclk edge):
//   level=0, o_valid=0, o_data=0, pop_cnt=0, stall_cnt=0.
//   rget is held 0 combinationally while rrst=1.
//   Reset mid-operation discards buffered words. The FIFO itself is not popped.
//  Handshakes:
//   take = o_valid & o_ready.
//   rget = ~rrst & ~flush & en & ~rempty & (level!=2 | take). rget is combinational.
//  Buffer: two registers, head (drives o_data) and tail. o_valid = (level!=0).
//   rget only:      word goes to head if level=0, otherwise to tail; level+1.
//   take only:      tail moves to head; level-1.
//   rget and take:
//    - level=1: rdata goes to head.
//    - level=2: tail goes to head, rdata goes to tail.
//    - level is unchanged in both cases.
//  Latency: a word popped at edge N is on o_data with o_valid=1 after edge N. Fall-through is 1 cycle.
//  Throughput: 1 word/cycle sustained while ~rempty and o_ready.
//  Ordering: strict FIFO order. No duplication or loss except by flush or rrst.
//  o_data holds its value while o_valid=1 and o_ready=0. Sinks may rely on this.
//  Full buffer: level=2 & ~o_ready -> rget=0. The FIFO then back-pressures the writer via wfull.
//  FIFO empty: rget=0. Buffered words continue to drain.
//  flush=1: level goes to 0 and o_valid goes to 0 at the next edge. rget=0 in that cycle.
//   A take in the flush cycle still completes as far as the sink is concerned.
//   flush has priority over all buffer updates.
//  en=0 blocks only popping. Draining and counters are unaffected.
//  pop_cnt: +1 on every edge where rget=1. Wraps modulo 2^cnt_size.
//  stall_cnt: +1 on every edge where o_valid & ~o_ready. Saturates at all-ones.
//  level, pop_cnt and stall_cnt are all registered.
// TESTING
//  1. Reset: hold rrst 3 cycles with rempty=0 -> rget=0 throughout; o_valid=0, o_data=0, level=0, counters=0.
//  2. Streaming: FIFO preloaded with 0x01..0x10, o_ready=1.
//     -> o_data carries 0x01..0x10 on 16 consecutive cycles, first word 1 cycle after the first rget.
//     -> pop_cnt=16 at the end.
//  3. Back-pressure: 0xA1,0xA2,0xA3 queued, o_ready=0 for 5 cycles.
//     -> level=2, rget=0, o_data=0xA1 stable, stall_cnt=5.
//     -> then o_ready=1: o_data shows 0xA1,0xA2,0xA3 on consecutive cycles.
//  4. Simultaneous pop and take at level=2 with FIFO non-empty:
//     -> level stays 2, order preserved, no bubble on o_valid.
//  5. Flush at level=2 -> next cycle level=0, o_valid=0.
//     -> the next FIFO word appears 1 cycle after flush is released.
//  6. Counters: with cnt_size=4, pop 17 words -> pop_cnt=1.
//     -> stall 20 cycles -> stall_cnt=15, saturated.

Source files
------------

// File: rtl/k_fifo_rd_stream_t1.sv
// k_fifo_rd_stream_t1: pops an async-FIFO read port into a 2-entry registered valid/ready stream with pop/stall stats
module k_fifo_rd_stream_t1 #(
  parameter int data_size = 8,
  parameter int cnt_size = 16
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic [data_size-1:0] rdata,
  input  logic                 rempty,
  output logic                 rget,
  input  logic                 en,
  input  logic                 flush,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [data_size-1:0] o_data,
  output logic [1:0]           level,
  output logic [cnt_size-1:0]  pop_cnt,
  output logic [cnt_size-1:0]  stall_cnt
);
  logic [data_size-1:0] head, tail;
  logic take, ld_head, ld_tail;
  assign take = o_valid & o_ready;
  assign rget = ~rrst & ~flush & en & ~rempty & (level != 2'd2 | take);
  assign ld_head = rget & (level == 2'd0 | (take & level == 2'd1));
  assign ld_tail = rget & ~ld_head;
  assign o_valid = level != 2'd0;
  assign o_data = head;
  always_ff @(posedge rclk)
    if (rrst) begin
      level <= '0;
      head <= '0;
      tail <= '0;
      pop_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      pop_cnt <= pop_cnt + cnt_size'(rget);
      if (o_valid && !o_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + cnt_size'(1);
      if (flush) level <= '0;
      else begin
        head <= ld_head ? rdata : take ? tail : head;
        if (ld_tail) tail <= rdata;
        level <= level + 2'(rget) - 2'(take);
      end
    end
endmodule

// File: tb/tb_k_fifo_rd_stream_t1.sv
// tb_k_fifo_rd_stream_t1: directed vector table plus hand sequences against a queue-modelled FIFO
module tb_k_fifo_rd_stream_t1;
  logic rclk, rrst, rempty, en, flush, o_ready;
  logic [7:0] rdata;
  logic rget, o_valid, rget4, o_valid4;
  logic [7:0] o_data, o_data4;
  logic [1:0] level, level4;
  logic [15:0] pop_cnt, stall_cnt;
  logic [3:0] pop_cnt4, stall_cnt4;
  int ncmp = 0, nerr = 0;
  logic [7:0] q[$];

  k_fifo_rd_stream_t1 #(.data_size(8), .cnt_size(16)) dut (
    .rclk(rclk), .rrst(rrst), .rdata(rdata), .rempty(rempty), .rget(rget), .en(en),
    .flush(flush), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .level(level),
    .pop_cnt(pop_cnt), .stall_cnt(stall_cnt));
  k_fifo_rd_stream_t1 #(.data_size(8), .cnt_size(4)) dut4 (
    .rclk(rclk), .rrst(rrst), .rdata(rdata), .rempty(rempty), .rget(rget4), .en(en),
    .flush(flush), .o_valid(o_valid4), .o_ready(o_ready), .o_data(o_data4), .level(level4),
    .pop_cnt(pop_cnt4), .stall_cnt(stall_cnt4));

  initial rclk = 0;
  always #5 rclk = ~rclk;

  typedef struct {
    logic rempty; logic [7:0] rdata; logic en; logic flush; logic o_ready;
    logic e_rget; logic e_valid; logic [7:0] e_data; logic [1:0] e_level;
  } vec_t;
  vec_t v[11];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic upd();
    rempty = q.size() == 0;
    rdata = rempty ? 8'h00 : q[0];
  endtask

  task automatic step();
    logic g;
    #1 g = rget;
    @(posedge rclk);
    #1;
    if (g && q.size() > 0) void'(q.pop_front());
    upd();
  endtask

  task automatic do_reset();
    rrst = 1;
    q.delete();
    upd();
    step();
    rrst = 0;
  endtask

  initial begin
    rrst = 1; en = 1; flush = 0; o_ready = 1;
    q = '{8'h5A};
    upd();
    for (int i = 0; i < 3; i++) begin
      #1 chk("reset_rget", rget, 0);
      step();
    end
    chk("reset_valid", o_valid, 0);
    chk("reset_data", o_data, 0);
    chk("reset_level", level, 0);
    chk("reset_pop", pop_cnt, 0);
    chk("reset_stall", stall_cnt, 0);
    rrst = 0;
    q.delete();
    for (int i = 1; i <= 16; i++) q.push_back(8'(i));
    upd();
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("stream_valid", o_valid, 1);
      chk("stream_data", o_data, i);
    end
    chk("stream_pop", pop_cnt, 16);
    step();
    chk("stream_drain", level, 0);
    o_ready = 0;
    q = '{8'hA1, 8'hA2, 8'hA3};
    upd();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", o_data, 8'hA1);
    end
    chk("bp_level", level, 2);
    #1 chk("bp_rget", rget, 0);
    chk("bp_stall", stall_cnt, 5);
    o_ready = 1;
    step();
    chk("bp_a2", o_data, 8'hA2);
    step();
    chk("bp_a3", o_data, 8'hA3);
    chk("bp_a3_valid", o_valid, 1);
    step();
    chk("bp_empty", o_valid, 0);
    chk("bp_stall_kept", stall_cnt, 5);
    o_ready = 0;
    q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6};
    upd();
    step();
    step();
    chk("sim_full", level, 2);
    o_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sim_level", level, 2);
      chk("sim_valid", o_valid, 1);
      chk("sim_data", o_data, 8'hB2 + 8'(i));
    end
    step();
    chk("sim_b6", o_data, 8'hB6);
    step();
    chk("sim_drain", level, 0);
    o_ready = 0;
    q = '{8'hC1, 8'hC2, 8'hC3};
    upd();
    step();
    step();
    chk("fl_full", level, 2);
    flush = 1;
    #1 chk("fl_rget", rget, 0);
    step();
    chk("fl_level", level, 0);
    chk("fl_valid", o_valid, 0);
    chk("fl_stall", stall_cnt, 8);
    flush = 0;
    o_ready = 1;
    step();
    chk("fl_next_valid", o_valid, 1);
    chk("fl_next_data", o_data, 8'hC3);
    step();
    do_reset();
    chk("c_reset", pop_cnt4, 0);
    for (int i = 0; i < 17; i++) q.push_back(8'h70 + 8'(i));
    upd();
    for (int i = 0; i < 18; i++) step();
    chk("c_pop_wrap", pop_cnt4, 1);
    chk("c_pop_wide", pop_cnt, 17);
    o_ready = 0;
    q = '{8'hD0};
    upd();
    step();
    for (int i = 0; i < 20; i++) step();
    chk("c_stall_sat", stall_cnt4, 15);
    chk("c_stall_wide", stall_cnt, 20);
    do_reset();
    chk("mid_reset_level", level, 0);
    chk("mid_reset_valid", o_valid, 0);
    chk("mid_reset_data", o_data, 0);
    v[0]  = '{0, 8'h11, 0, 0, 1, 0, 0, 8'h00, 0};
    v[1]  = '{0, 8'h11, 1, 0, 0, 1, 1, 8'h11, 1};
    v[2]  = '{0, 8'h22, 1, 0, 0, 1, 1, 8'h11, 2};
    v[3]  = '{0, 8'h33, 1, 0, 0, 0, 1, 8'h11, 2};
    v[4]  = '{0, 8'h33, 0, 0, 1, 0, 1, 8'h22, 1};
    v[5]  = '{1, 8'h33, 1, 0, 1, 0, 0, 8'h00, 0};
    v[6]  = '{0, 8'h44, 1, 0, 1, 1, 1, 8'h44, 1};
    v[7]  = '{0, 8'h55, 1, 1, 1, 0, 0, 8'h00, 0};
    v[8]  = '{0, 8'h55, 1, 0, 1, 1, 1, 8'h55, 1};
    v[9]  = '{0, 8'h66, 1, 0, 1, 1, 1, 8'h66, 1};
    v[10] = '{1, 8'h66, 1, 0, 1, 0, 0, 8'h00, 0};
    for (int i = 0; i < 11; i++) begin
      rempty = v[i].rempty; rdata = v[i].rdata; en = v[i].en;
      flush = v[i].flush; o_ready = v[i].o_ready;
      #1 chk($sformatf("vec%0d_rget", i), rget, v[i].e_rget);
      @(posedge rclk);
      #1 chk($sformatf("vec%0d_valid", i), o_valid, v[i].e_valid);
      chk($sformatf("vec%0d_level", i), level, v[i].e_level);
      if (v[i].e_valid) chk($sformatf("vec%0d_data", i), o_data, v[i].e_data);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
